// File: rtl/esteira_pkg.sv
// Shared types and default constants for the conveyor station sequencer.
package esteira_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_MOVE    = 3'd1,
    S_FILL    = 3'd2,
    S_CAP     = 3'd3,
    S_RELEASE = 3'd4,
    S_FAULT   = 3'd5
  } state_e;

  localparam int DIV_DEF      = 25_000_000;
  localparam int FILL_TMO_DEF = 10;
  localparam int CAP_T_DEF    = 2;

endpackage

// File: rtl/esteira_ctrl_if.sv
// Station I/O bundle: operator/sensor inputs and actuator/status outputs.
// batch_done exists only when BATCH_STOP_EN is defined.
interface esteira_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic             stop;
  logic             sensor_pos;
  logic             level_full;
  logic             motor_en;
  logic             valve_open;
  logic             cap_cmd;
  logic [CNT_W-1:0] bottle_count;
  logic             busy;
  logic             fault;
`ifdef BATCH_STOP_EN
  logic             batch_done;
`endif

  modport slave (
    input  start, stop, sensor_pos, level_full,
    output motor_en, valve_open, cap_cmd, bottle_count, busy, fault
`ifdef BATCH_STOP_EN
    , output batch_done
`endif
  );

  modport master (
    output start, stop, sensor_pos, level_full,
    input  motor_en, valve_open, cap_cmd, bottle_count, busy, fault
`ifdef BATCH_STOP_EN
    , input batch_done
`endif
  );
endinterface

// File: rtl/esteira_ctrl_tick_gen.sv
// Resettable tick prescaler: counts 0..DIV-1 while enabled, pulses tick at DIV-1.
module tick_gen
  import esteira_pkg::*;
#(
  parameter int DIV   = DIV_DEF,
  parameter int DIV_W = 25
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic tick
);
  localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)       cnt_d = '0;
    else if (enable) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  // tick is deliberately not gated by clear: clear depends on tick via the FSM
  assign tick = enable && (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/esteira_ctrl.sv
// Conveyor station sequencer: move, fill, cap, release per bottle with tick timeouts.
// Define BATCH_STOP_EN to stop after BATCH bottles and raise batch_done.
module esteira_ctrl
  import esteira_pkg::*;
#(
  parameter int DIV      = DIV_DEF,
  parameter int DIV_W    = 25,
  parameter int FILL_TMO = FILL_TMO_DEF,
  parameter int CAP_T    = CAP_T_DEF,
  parameter int CNT_W    = 8
`ifdef BATCH_STOP_EN
  , parameter int BATCH  = 12
`endif
) (
  input logic           clk,
  input logic           rst_n,
  esteira_ctrl_if.slave bus
);
  localparam int TMAX   = (FILL_TMO > CAP_T) ? FILL_TMO : CAP_T;
  localparam int TCNT_W = $clog2(TMAX + 1);

  state_e            state_q, state_d;
  logic [TCNT_W-1:0] tcnt_q;
  logic [CNT_W-1:0]  count_q;
  logic              stop_pend_q, stop_pend_d;
  logic              motor_q, valve_q, cap_q, busy_q, fault_q;
  logic              tick, in_timed, trans, fill_tmo, cap_end, bottle_done, batch_hit;

  assign in_timed    = state_q inside {S_FILL, S_CAP, S_RELEASE};
  assign trans       = (state_d != state_q);
  assign fill_tmo    = tick && (tcnt_q == TCNT_W'(FILL_TMO - 1));
  assign cap_end     = tick && (tcnt_q == TCNT_W'(CAP_T - 1));
  assign bottle_done = (state_q == S_CAP) && (state_d == S_RELEASE);

  tick_gen #(.DIV(DIV), .DIV_W(DIV_W)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (in_timed),
    .clear  (trans),
    .tick   (tick)
  );

`ifdef BATCH_STOP_EN
  localparam int BCNT_W = $clog2(BATCH + 1);
  logic [BCNT_W-1:0] bcnt_q;
  logic              bdone_q;

  assign batch_hit      = (bcnt_q == BCNT_W'(BATCH));
  assign bus.batch_done = bdone_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt_q  <= '0;
      bdone_q <= 1'b0;
    end else if (state_q == S_IDLE && state_d == S_MOVE) begin
      bcnt_q  <= '0;
      bdone_q <= 1'b0;
    end else begin
      if (bottle_done) bcnt_q <= bcnt_q + 1'b1;
      if (state_q == S_RELEASE && state_d == S_IDLE && batch_hit) bdone_q <= 1'b1;
    end
  end
`else
  assign batch_hit = 1'b0;
`endif

  // Normal exits are tested before timeouts so they win a same-cycle tie
  always_comb begin
    state_d     = state_q;
    stop_pend_d = stop_pend_q;
    case (state_q)
      S_IDLE:    if (bus.start && !bus.stop) state_d = S_MOVE;
      S_MOVE:    if (bus.stop) state_d = S_IDLE;
                 else if (bus.sensor_pos) state_d = S_FILL;
      S_FILL:    if (bus.level_full) state_d = S_CAP;
                 else if (fill_tmo) state_d = S_FAULT;
      S_CAP:     if (cap_end) state_d = S_RELEASE;
      S_RELEASE: if (!bus.sensor_pos)
                   state_d = (stop_pend_q || bus.stop || batch_hit) ? S_IDLE : S_MOVE;
                 else if (fill_tmo) state_d = S_FAULT;
      S_FAULT:   if (bus.stop) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (state_d == S_IDLE || state_d == S_FAULT || (state_q == S_RELEASE && trans))
      stop_pend_d = 1'b0;
    else if (bus.stop && in_timed)
      stop_pend_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      tcnt_q      <= '0;
      count_q     <= '0;
      stop_pend_q <= 1'b0;
      motor_q     <= 1'b0;
      valve_q     <= 1'b0;
      cap_q       <= 1'b0;
      busy_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      stop_pend_q <= stop_pend_d;
      if (trans)     tcnt_q <= '0;
      else if (tick) tcnt_q <= tcnt_q + 1'b1;
      if (bottle_done) count_q <= count_q + 1'b1;
      motor_q <= (state_d == S_MOVE) || (state_d == S_RELEASE);
      valve_q <= (state_d == S_FILL);
      cap_q   <= (state_d == S_CAP);
      busy_q  <= (state_d != S_IDLE) && (state_d != S_FAULT);
      fault_q <= (state_d == S_FAULT);
    end
  end

  assign bus.motor_en     = motor_q;
  assign bus.valve_open   = valve_q;
  assign bus.cap_cmd      = cap_q;
  assign bus.busy         = busy_q;
  assign bus.fault        = fault_q;
  assign bus.bottle_count = count_q;
endmodule

// File: tb/tb_esteira_ctrl.sv
// Bench for esteira_ctrl: cycle-count reference model plus directed and random stimulus.
// Covers the BATCH_STOP_EN build as well when that macro is defined.
module tb_esteira_ctrl;
  localparam int DIV = 4, FILL_TMO = 3, CAP_T = 2, CNT_W = 8, BATCH = 3;
  localparam int FILL_CYC = FILL_TMO * DIV;
  localparam int CAP_CYC  = CAP_T * DIV;
  localparam int P_IDLE = 0, P_MOVE = 1, P_FILL = 2, P_CAP = 3, P_REL = 4, P_FAULT = 5;
`ifdef BATCH_STOP_EN
  localparam bit BATCH_EN = 1'b1;
`else
  localparam bit BATCH_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  bit   chk_on = 1'b0;

  esteira_ctrl_if #(.CNT_W(CNT_W)) bus ();

  esteira_ctrl #(
    .DIV(DIV), .DIV_W(3), .FILL_TMO(FILL_TMO), .CAP_T(CAP_T), .CNT_W(CNT_W)
`ifdef BATCH_STOP_EN
    , .BATCH(BATCH)
`endif
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phases with elapsed-cycle counts instead of prescaler ticks
  int m_ph = P_IDLE, m_cyc = 0, m_cnt = 0, m_bcnt = 0;
  bit m_pend = 1'b0, m_bdone = 1'b0;

  always @(posedge clk or negedge rst_n) begin : model
    int nx, cn, bc;
    bit bd, pn, in_t;
    if (!rst_n) begin
      m_ph <= P_IDLE; m_cyc <= 0; m_cnt <= 0; m_bcnt <= 0; m_pend <= 1'b0; m_bdone <= 1'b0;
    end else begin
      nx = m_ph; cn = m_cnt; bc = m_bcnt; bd = m_bdone; pn = m_pend;
      in_t = (m_ph == P_FILL) || (m_ph == P_CAP) || (m_ph == P_REL);
      case (m_ph)
        P_IDLE:  if (bus.start && !bus.stop) begin nx = P_MOVE; bc = 0; bd = 1'b0; end
        P_MOVE:  if (bus.stop) nx = P_IDLE; else if (bus.sensor_pos) nx = P_FILL;
        P_FILL:  if (bus.level_full) nx = P_CAP; else if (m_cyc == FILL_CYC - 1) nx = P_FAULT;
        P_CAP:   if (m_cyc == CAP_CYC - 1) begin
                   nx = P_REL; cn = (m_cnt + 1) % (1 << CNT_W); bc = m_bcnt + 1;
                 end
        P_REL:   if (!bus.sensor_pos) begin
                   if (BATCH_EN && m_bcnt == BATCH) begin nx = P_IDLE; bd = 1'b1; end
                   else if (m_pend || bus.stop) nx = P_IDLE;
                   else nx = P_MOVE;
                 end else if (m_cyc == FILL_CYC - 1) nx = P_FAULT;
        P_FAULT: if (bus.stop) nx = P_IDLE;
        default: nx = P_IDLE;
      endcase
      if (nx == P_IDLE || nx == P_FAULT || (m_ph == P_REL && nx != P_REL)) pn = 1'b0;
      else if (bus.stop && in_t) pn = 1'b1;
      m_cyc   <= (nx != m_ph) ? 0 : m_cyc + 1;
      m_ph    <= nx;
      m_cnt   <= cn;
      m_bcnt  <= bc;
      m_bdone <= bd;
      m_pend  <= pn;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("motor_en", int'(bus.motor_en), int'(m_ph == P_MOVE || m_ph == P_REL));
      chk("valve_open", int'(bus.valve_open), int'(m_ph == P_FILL));
      chk("cap_cmd", int'(bus.cap_cmd), int'(m_ph == P_CAP));
      chk("busy", int'(bus.busy), int'(m_ph != P_IDLE && m_ph != P_FAULT));
      chk("fault", int'(bus.fault), int'(m_ph == P_FAULT));
      chk("bottle_count", int'(bus.bottle_count), m_cnt);
      chk("no_overlap", int'((32'(bus.motor_en) + 32'(bus.valve_open) + 32'(bus.cap_cmd)) <= 1), 1);
`ifdef BATCH_STOP_EN
      chk("batch_done", int'(bus.batch_done), int'(m_bdone));
`endif
    end
  end

  function automatic int get_sig(input int which);
    case (which)
      0: return int'(bus.motor_en);
      1: return int'(bus.valve_open);
      2: return int'(bus.cap_cmd);
      3: return int'(bus.fault);
      default: return int'(bus.busy);
    endcase
  endfunction

  task automatic wait_sig(input int which, input int maxc);
    int n = 0;
    while (get_sig(which) == 0 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("wait_sig%0d", which), get_sig(which), 1);
  endtask

  // One cooperative bottle starting from IDLE (start held) or MOVE
  task automatic run_bottle();
    bus.start = 1'b1;
    wait_sig(0, 5);
    bus.sensor_pos = 1'b1;
    wait_sig(1, 5);
    repeat ($urandom_range(0, 4)) @(negedge clk);
    bus.level_full = 1'b1;
    wait_sig(2, 5);
    bus.level_full = 1'b0;
    wait_sig(0, 20);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    bus.sensor_pos = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int n, c0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.sensor_pos = 1'b0; bus.level_full = 1'b0;
    chk_on = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_count", int'(bus.bottle_count), 0);
    chk("rst_motor", int'(bus.motor_en), 0);
    chk("rst_busy", int'(bus.busy), 0);
    rst_n = 1'b1;

    // Normal bottle
    @(negedge clk); bus.start = 1'b1;
    wait_sig(0, 5);
    bus.sensor_pos = 1'b1;
    wait_sig(1, 5);
    chk("fill_motor_off", int'(bus.motor_en), 0);
    repeat (5) @(negedge clk);
    bus.level_full = 1'b1;
    wait_sig(2, 5);
    bus.level_full = 1'b0;
    n = 0;
    while (bus.cap_cmd && n < 50) begin n++; @(negedge clk); end
    chk("cap_cycles", n, 8);
    chk("release_motor", int'(bus.motor_en), 1);
    chk("count_after_one", int'(bus.bottle_count), 1);
    bus.sensor_pos = 1'b0; bus.start = 1'b0;
    @(negedge clk); bus.stop = 1'b1;
    @(negedge clk); bus.stop = 1'b0;
    chk("idle_after_stop", int'(bus.busy), 0);

    // Fill timeout
    bus.start = 1'b1;
    wait_sig(0, 5);
    bus.sensor_pos = 1'b1; bus.start = 1'b0;
    wait_sig(1, 5);
    n = 0;
    while (bus.valve_open && n < 50) begin n++; @(negedge clk); end
    chk("fill_tmo_cycles", n, 12);
    chk("fault_set", int'(bus.fault), 1);
    bus.start = 1'b1;
    repeat (2) @(negedge clk);
    chk("fault_ignores_start", int'(bus.fault), 1);
    bus.start = 1'b0; bus.sensor_pos = 1'b0; bus.stop = 1'b1;
    @(negedge clk); bus.stop = 1'b0;
    chk("fault_cleared", int'(bus.fault), 0);
    chk("fault_idle", int'(bus.busy), 0);

    // Deferred stop during CAP
    c0 = int'(bus.bottle_count);
    bus.start = 1'b1;
    wait_sig(0, 5);
    bus.sensor_pos = 1'b1;
    wait_sig(1, 5);
    bus.level_full = 1'b1;
    wait_sig(2, 5);
    bus.level_full = 1'b0; bus.start = 1'b0; bus.stop = 1'b1;
    @(negedge clk); bus.stop = 1'b0;
    wait_sig(0, 20);
    chk("deferred_count", int'(bus.bottle_count), (c0 + 1) % 256);
    bus.sensor_pos = 1'b0;
    @(negedge clk);
    chk("deferred_idle_busy", int'(bus.busy), 0);
    chk("deferred_idle_motor", int'(bus.motor_en), 0);

    // Counter wrap
    n = 0;
    while (int'(bus.bottle_count) != 255 && n < 300) begin run_bottle(); n++; end
    chk("preload_255", int'(bus.bottle_count), 255);
    run_bottle();
    chk("wrap_zero", int'(bus.bottle_count), 0);

    // Async reset mid-fill
    bus.start = 1'b1;
    wait_sig(0, 5);
    bus.sensor_pos = 1'b1;
    wait_sig(1, 5);
    c0 = int'(bus.valve_open);
    chk("pre_reset_valve", c0, 1);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("async_valve", int'(bus.valve_open), 0);
    chk("async_busy", int'(bus.busy), 0);
    chk("async_count", int'(bus.bottle_count), 0);
    @(negedge clk); rst_n = 1'b1;
    bus.start = 1'b0; bus.sensor_pos = 1'b0;
    @(negedge clk);

`ifdef BATCH_STOP_EN
    run_bottle(); run_bottle(); run_bottle();
    chk("batch_idle", int'(bus.busy), 0);
    chk("batch_done_set", int'(bus.batch_done), 1);
    @(negedge clk);
    chk("batch_restart", int'(bus.motor_en), 1);
    chk("batch_done_clr", int'(bus.batch_done), 0);
    bus.start = 1'b0; bus.stop = 1'b1;
    @(negedge clk); bus.stop = 1'b0;
`endif

    // Random stimulus against the model
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      bus.start = ($urandom_range(0, 3) != 0);
      bus.stop  = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 9) < 3) bus.sensor_pos = ~bus.sensor_pos;
      if ($urandom_range(0, 9) < 2) bus.level_full = ~bus.level_full;
    end
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
